// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// 16x-oversample tick generator: counts 0..BAUD_DIV-1 and pulses tick on wrap.
// A synchronous clear holds the count at zero.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  logic [15:0] cnt;

  assign tick = (cnt == LAST) && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, 8 data bits LSB first.
// Define UART_RX_PARITY_EN for an 8E1 frame; otherwise 8N1 with parity_err tied 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic       rx_s1, rx_s2, rx_prev;
  logic [2:0] settle;
  logic       start_edge;

  state_t     state, state_next;
  logic       tick;
  logic       sample;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;

  // settle gates edge detection until rx_prev holds a real line sample,
  // so a line already low at reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      settle  <= {settle[1:0], 1'b1};
    end
  end

  assign start_edge = settle[2] && rx_prev && !rx_s2;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_next = START;
      end
      START: begin
        if (tick && os_cnt == MID_LAST) begin
          sample     = 1'b1;
          state_next = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && os_cnt == OS_LAST) begin
          sample = 1'b1;
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && os_cnt == OS_LAST) begin
          sample     = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && os_cnt == OS_LAST) begin
          sample     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // os_cnt restarts at the mid-start sample, then wraps every 16 ticks
  // so later samples land in the middle of each bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        os_cnt <= '0;
      end else if (tick) begin
        os_cnt <= (state == START && sample) ? '0 : os_cnt + 4'd1;
      end
      if (state == START) begin
        bit_cnt <= '0;
      end else if (state == DATA && sample) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == DATA && sample) begin
        shift_reg <= {rx_s2, shift_reg[7:1]};
      end
      if (state == STOP && sample) begin
        if (rx_s2) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == PARITY && sample) begin
        par_bit <= rx_s2;
      end
      if (state == STOP && sample && rx_s2) begin
        parity_err <= (par_bit != ^shift_reg);
      end
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx (BAUD_DIV=4, one bit = 64 clk).
// Parity frames are exercised only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int unsigned BD  = 4;
  localparam int unsigned BIT = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx #(
    .BAUD_DIV(BD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       perr;
    logic       is_err;
    logic [7:0] data;
  } ev_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  longint      cyc = 0;
  longint      last_valid_cyc = 0;
  longint      start_cyc;
  int unsigned perr_orphans = 0;
  ev_t         obs_q[$];
  ev_t         exp_q[$];
  logic [7:0]  last_good;

  always @(posedge clk) cyc++;

  // Observer: every output pulse becomes one event with the data visible at that time.
  always @(negedge clk) begin
    if (rx_valid) begin
      obs_q.push_back({parity_err, 1'b0, rx_data});
      last_valid_cyc = cyc;
    end
    if (frame_err) obs_q.push_back({1'b0, 1'b1, rx_data});
    if (parity_err && !rx_valid) perr_orphans++;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference model: a frame with a good stop bit yields its byte; a bad stop
  // bit yields a frame error showing the last good byte.
  task automatic expect_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    logic pe;
    pe = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe = par_flip;
`endif
    if (stop) begin
      exp_q.push_back({pe, 1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back({1'b0, 1'b1, last_good});
    end
  endtask

  task automatic drive_bit(input logic b, input logic cb);
    rx = b;
    repeat (BIT / 2) @(negedge clk);
    if (cb) chk("busy_mid_bit", 32'(busy), 32'd1);
    repeat (BIT / 2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip, input logic cb);
    drive_bit(1'b0, cb);
    for (int i = 0; i < 8; i++) drive_bit(d[i], cb);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip, cb);
`endif
    drive_bit(stop, cb);
    expect_frame(d, stop, par_flip);
  endtask

  task automatic idle(input int unsigned nbits);
    rx = 1'b1;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int unsigned n;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < int'(n); i++) chk({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    longint     lat;

    reset = 1'b1;
    rx    = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(2);

    // Single 0xA5 frame: data, latency from start edge, busy across the frame
    start_cyc = cyc;
    send(8'hA5, 1'b1, 1'b0, 1'b1);
    idle(1);
    drain("a5");
    lat = last_valid_cyc - start_cyc;
    chk("a5_latency_window", 32'(lat >= 600 && lat <= 620), 32'd1);
    chk("a5_rx_data", 32'(rx_data), 32'hA5);

    // 20-clk glitch is rejected at the mid-start resample
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("glitch_busy", 32'(busy), 32'd0);
    idle(1);
    drain("glitch");

    // Bad stop bit followed by a held-low break
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("break_busy", 32'(busy), 32'd0);
    idle(1);
    drain("ferr");
    chk("ferr_keeps_data", 32'(rx_data), 32'hA5);

    // Back-to-back frames with no idle gap
    send(8'h00, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain("b2b");

    // Reset after the 4th data bit of 0x5A, then receive 0x81
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i), 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_rx_data", 32'(rx_data), 32'h00);
    chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(1);
    drain("midrst");
    send(8'h81, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain("after_rst");

    // Line already low when reset releases must not start a frame
    rx = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4 * BIT) @(negedge clk);
    chk("low_at_release_busy", 32'(busy), 32'd0);
    idle(1);
    last_good = 8'h00;
    drain("low_at_release");
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain("low_then_frame");

    // Random bytes, mostly good stop bits, random 0/1-bit gaps
    for (int k = 0; k < 12; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send(d, stop, 1'b0, 1'b0);
      if (!stop || $urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);
    drain("random");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 1'b0);
    send(8'h07, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain("parity");
`endif

    chk("parity_err_without_valid", 32'(perr_orphans), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
